// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM state encoding plus
// small elaboration-time helpers (ceil-log2 width, max, one-hot decode).
package i2c_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_RUN       = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    // Ceil-log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] onehot(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Request/grant and I2C-master handshake bundle for the bus arbiter.
//   i_req       requester level requests      i_i2c_busy  master busy level
//   o_i2c_start 1-cycle master start pulse    o_gnt       one-hot grant
//   o_done      1-cycle completion pulse      o_timeout   1-cycle abort pulse
//   o_idle      arbiter is in IDLE
// slave  : arbiter side.  master : requesters + I2C master side.
interface i2c_bus_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0] i_req;
    logic             i_i2c_busy;
    logic             o_i2c_start;
    logic [N_REQ-1:0] o_gnt;
    logic [N_REQ-1:0] o_done;
    logic [N_REQ-1:0] o_timeout;
    logic             o_idle;

    modport slave (
        input  i_req, i_i2c_busy,
        output o_i2c_start, o_gnt, o_done, o_timeout, o_idle
    );

    modport master (
        output i_req, i_i2c_busy,
        input  o_i2c_start, o_gnt, o_done, o_timeout, o_idle
    );
endinterface

// File: rtl/i2c_bus_arbiter_ms_tick_gen.sv
// Millisecond timebase: prescaler 0..CLK_PER_MS-1 and a saturating ms count.
// Ports: clk, rst_n (sync, active-low), clr (sync clear),
//        tick (prescaler at terminal count), ms (elapsed whole ms).
module ms_tick_gen
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int CLK_PER_MS = 60000,
    parameter int MS_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic            tick,
    output logic [MS_W-1:0] ms
);
    localparam int PW = clog2(CLK_PER_MS);

    logic [PW-1:0] pre;

    assign tick = (pre == PW'(CLK_PER_MS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pre <= '0;
            ms  <= '0;
        end else if (tick) begin
            pre <= '0;
            if (ms != '1) ms <= ms + 1'b1;  // saturate rather than wrap
        end else begin
            pre <= pre + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master among N_REQ requesters. Round-robin grant, start
// pulse, completion on busy falling edge, per-transaction timeout and a
// fixed idle gap after every transaction.
// Ports: i_clk, i_rst_n (sync, active-low), bus (i2c_bus_arbiter_if.slave).
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int CLK_PER_MS = 60000,
    parameter int GAP_MS     = 15,
    parameter int TIMEOUT_MS = 200
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    i2c_bus_arbiter_if.slave     bus
);
    localparam int IW   = clog2(N_REQ);
    localparam int MS_W = clog2(max2(GAP_MS, TIMEOUT_MS) + 1);

    state_t            state, nxt;
    logic [IW-1:0]     ptr, win, pick;
    logic              any_req;
    logic              busy_d, fall;
    logic              tick, tmr_clr, to_exp, gap_exp;
    logic [MS_W-1:0]   ms;
    logic              start_nxt;
    logic [N_REQ-1:0]  win_oh, done_nxt, to_nxt;

    // The timebase is not cleared on WAIT_BUSY->RUN: the timeout window
    // runs from grant to busy fall across both states.
    assign tmr_clr = (state == ST_IDLE) || ((nxt != state) && (nxt != ST_RUN));

    ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS), .MS_W(MS_W)) u_tmr (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .clr  (tmr_clr),
        .tick (tick),
        .ms   (ms)
    );

    // Expiry fires on the last cycle of the window, so the registered
    // pulse / state change lands exactly N ms after state entry.
    assign to_exp  = tick && (ms == MS_W'(TIMEOUT_MS - 1));
    assign gap_exp = tick && (ms == MS_W'(GAP_MS - 1));
    assign fall    = busy_d && !bus.i_i2c_busy;
    assign win_oh  = N_REQ'(onehot(int'(win)));

    // Round-robin: first requester at or after ptr, wrapping.
    always_comb begin
        pick    = ptr;
        any_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx -= N_REQ;
            if (!any_req && bus.i_req[IW'(idx)]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            win             <= '0;
            busy_d          <= 1'b0;
            bus.o_i2c_start <= 1'b0;
            bus.o_done      <= '0;
            bus.o_timeout   <= '0;
        end else begin
            state           <= nxt;
            busy_d          <= bus.i_i2c_busy;
            bus.o_i2c_start <= start_nxt;
            bus.o_done      <= done_nxt;
            bus.o_timeout   <= to_nxt;
            if (state == ST_IDLE && any_req) begin
                win <= pick;
                ptr <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:      if (any_req) nxt = ST_WAIT_BUSY;
            // Timeout takes priority over a late busy rise.
            ST_WAIT_BUSY: if (to_exp) nxt = ST_GAP;
                          else if (bus.i_i2c_busy) nxt = ST_RUN;
            ST_RUN:       if (fall || to_exp) nxt = ST_GAP;
            ST_GAP:       if (gap_exp) nxt = ST_IDLE;
            default:      nxt = ST_IDLE;
        endcase
    end

    // Registered-output next values; done beats timeout on the same cycle.
    always_comb begin
        start_nxt = (state == ST_IDLE) && any_req;
        done_nxt  = (state == ST_RUN && fall) ? win_oh : '0;
        to_nxt    = '0;
        if ((state == ST_WAIT_BUSY && to_exp) || (state == ST_RUN && to_exp && !fall))
            to_nxt = win_oh;
    end

    assign bus.o_gnt  = (state == ST_WAIT_BUSY || state == ST_RUN) ? win_oh : '0;
    assign bus.o_idle = (state == ST_IDLE);
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;
    localparam int N = 3, CPM = 10, GAP = 2, TMO = 5;
    localparam int GAP_CYC = GAP * CPM, TMO_CYC = TMO * CPM;

    typedef enum logic [1:0] {K_START, K_DONE, K_TMO} kind_t;
    typedef struct { kind_t kind; logic [2:0] bits; int cyc; } evt_t;
    typedef struct { logic [2:0] req; int rise; int len; int drop; logic [2:0] gnt; kind_t kind; } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    int   cyc = 0, checks = 0, fails = 0;
    evt_t sbq[$];
    vec_t vt[11];

    i2c_bus_arbiter_if #(.N_REQ(N)) bus();

    i2c_bus_arbiter #(.N_REQ(N), .CLK_PER_MS(CPM), .GAP_MS(GAP), .TIMEOUT_MS(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk); #1;
    endtask

    task automatic push(input kind_t k, input logic [2:0] b, input int c);
        evt_t e;
        e.kind = k; e.bits = b; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input kind_t k, input logic [2:0] b);
        evt_t e;
        checks++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_evt cyc=%0d got kind=%0d bits=%b want none", cyc, k, b);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.bits != b || e.cyc != cyc) begin
                fails++;
                $display("FAIL evt got kind=%0d bits=%b cyc=%0d want kind=%0d bits=%b cyc=%0d",
                         k, b, cyc, e.kind, e.bits, e.cyc);
            end
        end
    endtask

    // Output monitor: every pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_i2c_start === 1'b1) sb_pop(K_START, bus.o_gnt);
            if (|bus.o_done)              sb_pop(K_DONE, bus.o_done);
            if (|bus.o_timeout)           sb_pop(K_TMO, bus.o_timeout);
            checks++;
            if ((|bus.o_done && |bus.o_timeout) || !$onehot0(bus.o_done) ||
                !$onehot0(bus.o_timeout) || !$onehot0(bus.o_gnt)) begin
                fails++;
                $display("FAIL pulse_excl cyc=%0d got done=%b tmo=%b gnt=%b want exclusive one-hot",
                         cyc, bus.o_done, bus.o_timeout, bus.o_gnt);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.o_idle !== 1'b1 && n < 200) begin tk(); n++; end
        if (bus.o_idle !== 1'b1) chk("wait_idle_bound", 32'(bus.o_idle), 32'd1);
    endtask

    task automatic run_txn(input vec_t v);
        int g, endc, last, rel;
        wait_idle();
        bus.i_req = v.req;
        g    = cyc + 1;
        endc = (v.kind == K_DONE) ? g + v.rise + v.len + 1 : g + TMO_CYC;
        last = (v.rise < 0) ? endc : ((endc > g + v.rise + v.len) ? endc : g + v.rise + v.len);
        push(K_START, v.gnt, g);
        push(v.kind, v.gnt, endc);
        do begin
            tk();
            rel = cyc - g;
            bus.i_i2c_busy = (v.rise >= 0) && (rel >= v.rise) && (rel < v.rise + v.len);
            if (rel == v.drop) bus.i_req = '0;
            if (cyc < endc) chk("gnt_hold", 32'(bus.o_gnt), 32'(v.gnt));
            else            chk("gnt_clear", 32'(bus.o_gnt), 32'd0);
        end while (cyc < last + 1);
        bus.i_i2c_busy = 1'b0;
        while (cyc < endc + GAP_CYC - 1) tk();
        chk("gap_not_idle", 32'(bus.o_idle), 32'd0);
        tk();
        chk("gap_end_idle", 32'(bus.o_idle), 32'd1);
        chk("sb_drained", sbq.size(), 32'd0);
    endtask

    initial begin
        int g;
        // req, rise, len, drop, expected grant, expected outcome
        vt[0]  = '{3'b010,  1,  8, -1, 3'b010, K_DONE};  // single request
        vt[1]  = '{3'b111,  1,  8, -1, 3'b100, K_DONE};  // rr continues after 1
        vt[2]  = '{3'b111,  1,  8, -1, 3'b001, K_DONE};
        vt[3]  = '{3'b111,  1,  8, -1, 3'b010, K_DONE};
        vt[4]  = '{3'b111,  1,  8, -1, 3'b100, K_DONE};
        vt[5]  = '{3'b001, -1,  0, -1, 3'b001, K_TMO };  // busy never rises
        vt[6]  = '{3'b010,  1, 48, -1, 3'b010, K_DONE};  // fall on timeout cycle
        vt[7]  = '{3'b100,  3, 60, -1, 3'b100, K_TMO };  // timeout in RUN
        vt[8]  = '{3'b110, 49,  5, -1, 3'b010, K_TMO };  // busy rises as timeout hits
        vt[9]  = '{3'b011,  2,  3,  4, 3'b001, K_DONE};  // req dropped in RUN
        vt[10] = '{3'b101,  1,  8, -1, 3'b100, K_DONE};

        bus.i_req = '0;
        bus.i_i2c_busy = 1'b0;
        tk(); tk();
        chk("rst_idle",  32'(bus.o_idle), 32'd1);
        chk("rst_gnt",   32'(bus.o_gnt), 32'd0);
        chk("rst_start", 32'(bus.o_i2c_start), 32'd0);
        chk("rst_done",  32'(bus.o_done), 32'd0);
        chk("rst_tmo",   32'(bus.o_timeout), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_txn(vt[i]);

        // Reset mid-RUN: outputs clear, pointer returns to 0.
        wait_idle();
        bus.i_req = 3'b010;
        g = cyc + 1;
        push(K_START, 3'b010, g);
        tk();
        bus.i_i2c_busy = 1'b1;
        tk(); tk();
        chk("pre_rst_gnt", 32'(bus.o_gnt), 32'b010);
        rst_n = 1'b0;
        tk();
        chk("mid_rst_idle",  32'(bus.o_idle), 32'd1);
        chk("mid_rst_gnt",   32'(bus.o_gnt), 32'd0);
        chk("mid_rst_start", 32'(bus.o_i2c_start), 32'd0);
        chk("mid_rst_done",  32'(bus.o_done), 32'd0);
        chk("mid_rst_tmo",   32'(bus.o_timeout), 32'd0);
        rst_n = 1'b1;
        bus.i_i2c_busy = 1'b0;
        bus.i_req = 3'b111;
        g = cyc + 1;
        push(K_START, 3'b001, g);
        push(K_TMO, 3'b001, g + TMO_CYC);
        while (cyc < g + TMO_CYC) tk();
        bus.i_req = '0;
        tk();
        chk("post_rst_drained", sbq.size(), 32'd0);
        wait_idle();
        tk(); tk();
        chk("final_drained", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end
endmodule
